// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake bundle for multicycle_ctrl.
// Carries the instruction-memory fetch channel and the data-memory
// access channel. Signal names match the original flat port names.
//   master : the sequencer (drives requests, consumes responses)
//   slave  : the memory system (accepts requests, returns responses)
interface multicycle_ctrl_if;
  // instruction memory
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  // data memory
  logic        io_dmem_req_valid;
  logic [1:0]  io_dmem_req_fcn;
  logic        io_dmem_req_ready;
  logic        io_dmem_resp_valid;

  modport master (
    output io_imem_req_valid, io_imem_req_addr,
    input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    output io_dmem_req_valid, io_dmem_req_fcn,
    input  io_dmem_req_ready, io_dmem_resp_valid
  );

  modport slave (
    input  io_imem_req_valid, io_imem_req_addr,
    output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    input  io_dmem_req_valid, io_dmem_req_fcn,
    output io_dmem_req_ready, io_dmem_resp_valid
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the single-issue RISC-V core.
// Owns PC and IR, steps FETCH -> DECODE -> EXEC -> MEM -> WB with valid/ready
// handshakes to instruction and data memory, qualifies register-file writes,
// retires instructions and redirects to TRAP_VEC on illegal instructions or
// misaligned control-flow targets.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   bus (master)      imem fetch channel and dmem access channel
//   io_dec_instr      IR contents to the decoder
//   io_ctl_*          decoder control outputs (val_inst, rf_wen, mem_en, mem_func)
//   io_br_taken/target datapath PC redirect
//   io_rf_wen         qualified regfile write strobe (WB only)
//   io_retire         one-cycle pulse per retired instruction
//   io_exc            one-cycle pulse on trap
//   io_pc, io_state   current PC and FSM state encoding
//
// Optional: define MULTICYCLE_CTRL_PERF_EN to add io_cycle_cnt (non-reset
// cycles) and io_instret_cnt (retired instructions), both wrapping 32-bit.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_2000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  multicycle_ctrl_if.master bus,
  output logic [31:0] io_dec_instr,
  input  logic        io_ctl_val_inst,
  input  logic        io_ctl_rf_wen,
  input  logic        io_ctl_mem_en,
  input  logic [1:0]  io_ctl_mem_func,
  input  logic        io_br_taken,
  input  logic [31:0] io_br_target,
  output logic        io_rf_wen,
  output logic        io_retire,
  output logic        io_exc,
  output logic [31:0] io_pc,
  output logic [2:0]  io_state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] io_cycle_cnt,
  output logic [31:0] io_instret_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    IWAIT  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    MWAIT  = 3'd5,
    WB     = 3'd6,
    TRAP   = 3'd7
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [1:0]  mem_fcn;

  logic imem_valid_s, dmem_valid_s, retire_s, rf_wen_s, exc_s;
  logic misaligned;

  assign misaligned = io_br_taken && (io_br_target[1:0] != 2'b00);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= NOP_INSTR;
      mem_fcn <= '0;
    end else begin
      state <= state_n;
      if (state == IWAIT && bus.io_imem_resp_valid)
        ir <= bus.io_imem_resp_data;
      if (state == EXEC)
        mem_fcn <= io_ctl_mem_func;
      if (state == WB && !misaligned)
        pc <= io_br_taken ? io_br_target : pc + 32'd4;
      else if (state == TRAP)
        pc <= TRAP_VEC;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_n      = state;
    imem_valid_s = 1'b0;
    dmem_valid_s = 1'b0;
    retire_s     = 1'b0;
    rf_wen_s     = 1'b0;
    exc_s        = 1'b0;
    case (state)
      FETCH: begin
        imem_valid_s = 1'b1;
        if (bus.io_imem_req_ready) state_n = IWAIT;
      end
      IWAIT:  if (bus.io_imem_resp_valid) state_n = DECODE;
      DECODE: state_n = io_ctl_val_inst ? EXEC : TRAP;
      EXEC:   state_n = io_ctl_mem_en ? MEM : WB;
      MEM: begin
        dmem_valid_s = 1'b1;
        if (bus.io_dmem_req_ready) state_n = MWAIT;
      end
      MWAIT:  if (bus.io_dmem_resp_valid) state_n = WB;
      WB: begin
        if (misaligned) begin
          state_n = TRAP;
        end else begin
          retire_s = 1'b1;
          rf_wen_s = io_ctl_rf_wen;
          state_n  = FETCH;
        end
      end
      TRAP: begin
        exc_s   = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  // Strobes are masked while reset is asserted so an outstanding request
  // is withdrawn in the same cycle reset arrives.
  assign bus.io_imem_req_valid = imem_valid_s & ~reset;
  assign bus.io_dmem_req_valid = dmem_valid_s & ~reset;
  assign io_retire             = retire_s & ~reset;
  assign io_rf_wen             = rf_wen_s & ~reset;
  assign io_exc                = exc_s & ~reset;

  assign bus.io_imem_req_addr = pc;
  assign bus.io_dmem_req_fcn  = mem_fcn;
  assign io_dec_instr         = ir;
  assign io_pc                = pc;
  assign io_state             = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      io_cycle_cnt   <= '0;
      io_instret_cnt <= '0;
    end else begin
      io_cycle_cnt <= io_cycle_cnt + 32'd1;
      if (io_retire) io_instret_cnt <= io_instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_2000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_dec_instr;
  logic        io_ctl_val_inst, io_ctl_rf_wen, io_ctl_mem_en;
  logic [1:0]  io_ctl_mem_func;
  logic        io_br_taken;
  logic [31:0] io_br_target;
  logic        io_rf_wen, io_retire, io_exc;
  logic [31:0] io_pc;
  logic [2:0]  io_state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] io_cycle_cnt, io_instret_cnt;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .RESET_PC (32'h0000_2000),
    .TRAP_VEC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .io_dec_instr   (io_dec_instr),
    .io_ctl_val_inst(io_ctl_val_inst),
    .io_ctl_rf_wen  (io_ctl_rf_wen),
    .io_ctl_mem_en  (io_ctl_mem_en),
    .io_ctl_mem_func(io_ctl_mem_func),
    .io_br_taken    (io_br_taken),
    .io_br_target   (io_br_target),
    .io_rf_wen      (io_rf_wen),
    .io_retire      (io_retire),
    .io_exc         (io_exc),
    .io_pc          (io_pc),
    .io_state       (io_state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .io_cycle_cnt   (io_cycle_cnt),
    .io_instret_cnt (io_instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: expected outcome of one instruction.
  typedef struct {
    bit          exc;
    bit          rf_wen;
    logic [31:0] pc;
    int unsigned cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mpc;  // model PC

  // Stimulus record for table-driven tests.
  typedef struct {
    logic [31:0] instr;
    bit          val, rfw, mem;
    logic [1:0]  func;
    bit          br;
    logic [31:0] tgt;
    int unsigned idly, ddly;
  } stim_t;

  // Observations from the last drive_instr call.
  logic        o_exc, o_retire, o_rf_wen;
  logic [31:0] o_pc;
  logic [2:0]  o_state;
  logic [1:0]  o_fcn;
  int unsigned o_cycles, o_dvalid, o_excl;
  bit          o_stray, o_timeout;

  // Reference model: outcome and request-to-event cycle count (counting the
  // first fetch-request cycle as 1).
  function automatic void predict(input stim_t s);
    exp_t e;
    int unsigned wb;
    if (!s.val) begin
      e.exc = 1; e.rf_wen = 0; e.cycles = 4 + s.idly; mpc = TVEC;
    end else begin
      wb = 5 + s.idly + (s.mem ? 2 + s.ddly : 0);
      if (s.br && s.tgt[1:0] != 2'b00) begin
        e.exc = 1; e.rf_wen = 0; e.cycles = wb + 1; mpc = TVEC;
      end else begin
        e.exc = 0; e.rf_wen = s.rfw; e.cycles = wb;
        mpc = s.br ? s.tgt : mpc + 32'd4;
      end
    end
    e.pc = mpc;
    sb.push_back(e);
  endfunction

  task automatic clear_mem_inputs();
    bus.io_imem_req_ready  = 0;
    bus.io_imem_resp_valid = 0;
    bus.io_imem_resp_data  = '0;
    bus.io_dmem_req_ready  = 0;
    bus.io_dmem_resp_valid = 0;
  endtask

  // Acts as memory + decoder for one instruction. Must be entered at a
  // negedge with the DUT in FETCH; returns at a negedge after the event.
  task automatic drive_instr(input stim_t s);
    int unsigned fw = 0, dw = 0;
    bit done = 0;
    io_ctl_val_inst = s.val; io_ctl_rf_wen = s.rfw; io_ctl_mem_en = s.mem;
    io_ctl_mem_func = s.func; io_br_taken = s.br; io_br_target = s.tgt;
    o_exc = 0; o_retire = 0; o_rf_wen = 0; o_fcn = 0;
    o_cycles = 0; o_dvalid = 0; o_excl = 0; o_stray = 0; o_timeout = 0;
    for (int unsigned n = 1; n <= 80 && !done; n++) begin
      if (n > 1) @(negedge clk);
      clear_mem_inputs();
      if (bus.io_imem_req_valid) begin
        bus.io_imem_req_ready = (fw >= s.idly);
        fw++;
      end
      if (io_state == 3'd1) begin
        bus.io_imem_resp_valid = 1;
        bus.io_imem_resp_data  = s.instr;
      end
      if (bus.io_dmem_req_valid) begin
        o_dvalid++;
        o_fcn = bus.io_dmem_req_fcn;
        bus.io_dmem_req_ready = (dw >= s.ddly);
        dw++;
      end
      if (io_state == 3'd5) bus.io_dmem_resp_valid = 1;
      if ((io_retire || io_exc || io_rf_wen) &&
          (bus.io_imem_req_valid || bus.io_dmem_req_valid)) o_excl++;
      if (io_rf_wen && !io_retire) o_stray = 1;
      if (io_retire || io_exc) begin
        o_retire = io_retire; o_exc = io_exc; o_rf_wen = io_rf_wen;
        o_cycles = n; done = 1;
      end
    end
    clear_mem_inputs();
    if (!done) o_timeout = 1;
    @(negedge clk);
    o_pc = io_pc;
    o_state = io_state;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_mem_inputs();
    io_ctl_val_inst = 0; io_ctl_rf_wen = 0; io_ctl_mem_en = 0;
    io_ctl_mem_func = 0; io_br_taken = 0; io_br_target = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_imem_valid_during got %b want 0", bus.io_imem_req_valid); end
    checks++; if ({io_retire, io_exc, io_rf_wen} !== 3'b000) begin errors++; $display("FAIL rst_strobes_during got %b want 000", {io_retire, io_exc, io_rf_wen}); end
    reset = 0;
    @(negedge clk);
    checks++; if (io_pc !== RST_PC) begin errors++; $display("FAIL rst_pc got %h want %h", io_pc, RST_PC); end
    checks++; if (io_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", io_state); end
    checks++; if (bus.io_imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_imem_valid got %b want 1", bus.io_imem_req_valid); end
    checks++; if (bus.io_imem_req_addr !== RST_PC) begin errors++; $display("FAIL rst_imem_addr got %h want %h", bus.io_imem_req_addr, RST_PC); end
    checks++; if (io_dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_ir got %h want 00000013", io_dec_instr); end
    checks++; if (bus.io_dmem_req_fcn !== 2'd0) begin errors++; $display("FAIL rst_fcn got %0d want 0", bus.io_dmem_req_fcn); end
    mpc = RST_PC;
  endtask

  task automatic test_alu();
    stim_t s = '{32'h0020_8133, 1, 1, 0, 2'd0, 0, 32'h0, 0, 0};
    exp_t e;
    predict(s);
    drive_instr(s);
    e = sb.pop_front();
    checks++; if (o_retire !== 1'b1 || o_exc !== 1'b0) begin errors++; $display("FAIL alu_retire got r%b e%b want r1 e0", o_retire, o_exc); end
    checks++; if (o_rf_wen !== e.rf_wen) begin errors++; $display("FAIL alu_rf_wen got %b want %b", o_rf_wen, e.rf_wen); end
    checks++; if (o_cycles != e.cycles) begin errors++; $display("FAIL alu_latency got %0d want %0d", o_cycles, e.cycles); end
    checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL alu_pc got %h want %h", o_pc, e.pc); end
    checks++; if (io_dec_instr !== s.instr) begin errors++; $display("FAIL alu_ir got %h want %h", io_dec_instr, s.instr); end
  endtask

  task automatic test_load();
    stim_t s = '{32'h0000_a103, 1, 1, 1, 2'd1, 0, 32'h0, 0, 3};
    exp_t e;
    predict(s);
    drive_instr(s);
    e = sb.pop_front();
    checks++; if (o_retire !== 1'b1 || o_rf_wen !== e.rf_wen) begin errors++; $display("FAIL load_retire got r%b w%b want r1 w%b", o_retire, o_rf_wen, e.rf_wen); end
    checks++; if (o_dvalid != 4) begin errors++; $display("FAIL load_dvalid_hold got %0d want 4", o_dvalid); end
    checks++; if (o_fcn !== 2'd1) begin errors++; $display("FAIL load_fcn got %0d want 1", o_fcn); end
    checks++; if (o_cycles != e.cycles) begin errors++; $display("FAIL load_latency got %0d want %0d", o_cycles, e.cycles); end
    checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL load_pc got %h want %h", o_pc, e.pc); end
  endtask

  task automatic test_illegal();
    stim_t s = '{32'hffff_ffff, 0, 1, 0, 2'd0, 0, 32'h0, 1, 0};
    exp_t e;
    predict(s);
    drive_instr(s);
    e = sb.pop_front();
    checks++; if (o_exc !== 1'b1 || o_retire !== 1'b0 || o_rf_wen !== 1'b0) begin errors++; $display("FAIL ill_kind got e%b r%b w%b want e1 r0 w0", o_exc, o_retire, o_rf_wen); end
    checks++; if (o_stray !== 1'b0) begin errors++; $display("FAIL ill_stray_wen got %b want 0", o_stray); end
    checks++; if (o_cycles != e.cycles) begin errors++; $display("FAIL ill_latency got %0d want %0d", o_cycles, e.cycles); end
    checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL ill_pc got %h want %h", o_pc, e.pc); end
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL ill_state got %0d want 0", o_state); end
  endtask

  task automatic test_branch();
    stim_t t[2];
    exp_t e;
    t[0] = '{32'h0000_006f, 1, 1, 0, 2'd0, 1, 32'h0000_3000, 2, 0};
    t[1] = '{32'h0000_006f, 1, 1, 0, 2'd0, 1, 32'h0000_3002, 0, 0};
    foreach (t[i]) begin
      predict(t[i]);
      drive_instr(t[i]);
      e = sb.pop_front();
      checks++; if (o_exc !== e.exc || o_retire !== !e.exc) begin errors++; $display("FAIL br%0d_kind got e%b r%b want e%b", i, o_exc, o_retire, e.exc); end
      checks++; if (o_rf_wen !== e.rf_wen || o_stray !== 1'b0) begin errors++; $display("FAIL br%0d_rf_wen got %b stray %b want %b", i, o_rf_wen, o_stray, e.rf_wen); end
      checks++; if (o_cycles != e.cycles) begin errors++; $display("FAIL br%0d_latency got %0d want %0d", i, o_cycles, e.cycles); end
      checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL br%0d_pc got %h want %h", i, o_pc, e.pc); end
    end
  endtask

  task automatic test_pc_wrap();
    stim_t t[2];
    exp_t e;
    t[0] = '{32'h0000_006f, 1, 0, 0, 2'd0, 1, 32'hffff_fffc, 0, 0};
    t[1] = '{32'h0000_0013, 1, 0, 0, 2'd0, 0, 32'h0000_0000, 0, 0};
    foreach (t[i]) begin
      predict(t[i]);
      drive_instr(t[i]);
      e = sb.pop_front();
      checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL wrap%0d_pc got %h want %h", i, o_pc, e.pc); end
    end
    checks++; if (bus.io_imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 00000000", bus.io_imem_req_addr); end
  endtask

  task automatic test_back_to_back();
    stim_t t[5];
    exp_t e;
    t[0] = '{32'h0020_a023, 1, 0, 1, 2'd2, 0, 32'h0, 0, 0};
    t[1] = '{32'h0000_0013, 1, 0, 0, 2'd0, 0, 32'h0, 3, 0};
    t[2] = '{32'h0000_0067, 1, 1, 0, 2'd0, 1, 32'h0000_4444, 0, 0};
    t[3] = '{32'h0000_2103, 1, 1, 1, 2'd1, 0, 32'h0, 1, 2};
    t[4] = '{32'h0000_0000, 0, 0, 0, 2'd0, 0, 32'h0, 0, 0};
    foreach (t[i]) predict(t[i]);
    foreach (t[i]) begin
      drive_instr(t[i]);
      e = sb.pop_front();
      checks++; if (o_timeout) begin errors++; $display("FAIL b2b%0d_timeout got no event want event", i); end
      checks++; if (o_exc !== e.exc || o_retire !== !e.exc || o_rf_wen !== e.rf_wen) begin errors++; $display("FAIL b2b%0d_kind got e%b r%b w%b want e%b w%b", i, o_exc, o_retire, o_rf_wen, e.exc, e.rf_wen); end
      checks++; if (o_excl != 0) begin errors++; $display("FAIL b2b%0d_excl got %0d overlaps want 0", i, o_excl); end
      checks++; if (o_cycles != e.cycles) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, o_cycles, e.cycles); end
      checks++; if (o_pc !== e.pc) begin errors++; $display("FAIL b2b%0d_pc got %h want %h", i, o_pc, e.pc); end
      if (t[i].mem) begin
        checks++; if (o_fcn !== t[i].func) begin errors++; $display("FAIL b2b%0d_fcn got %0d want %0d", i, o_fcn, t[i].func); end
      end
    end
  endtask

  task automatic test_reset_mwait();
    bit reached = 0;
    stim_t s;
    exp_t e;
    io_ctl_val_inst = 1; io_ctl_rf_wen = 1; io_ctl_mem_en = 1;
    io_ctl_mem_func = 2'd1; io_br_taken = 0; io_br_target = 0;
    for (int unsigned n = 0; n < 30 && !reached; n++) begin
      clear_mem_inputs();
      if (io_state == 3'd5) begin
        reached = 1;
      end else begin
        bus.io_imem_req_ready  = bus.io_imem_req_valid;
        bus.io_imem_resp_valid = (io_state == 3'd1);
        bus.io_imem_resp_data  = 32'h0000_2103;
        bus.io_dmem_req_ready  = bus.io_dmem_req_valid;
        @(negedge clk);
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rmw_reach got state %0d want 5", io_state); end
    reset = 1;
    @(negedge clk);
    checks++; if (io_state !== 3'd0) begin errors++; $display("FAIL rmw_state got %0d want 0", io_state); end
    checks++; if (bus.io_dmem_req_valid !== 1'b0 || bus.io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmw_valids got d%b i%b want d0 i0", bus.io_dmem_req_valid, bus.io_imem_req_valid); end
    checks++; if (io_pc !== RST_PC || bus.io_dmem_req_fcn !== 2'd0) begin errors++; $display("FAIL rmw_regs got pc %h fcn %0d want %h 0", io_pc, bus.io_dmem_req_fcn, RST_PC); end
    // late data response while fetch is stalled must be ignored
    reset = 0;
    bus.io_dmem_resp_valid = 1;
    repeat (2) @(negedge clk);
    checks++; if (io_state !== 3'd0 || {io_retire, io_rf_wen} !== 2'b00) begin errors++; $display("FAIL rmw_late_resp got state %0d r%b w%b want 0 r0 w0", io_state, io_retire, io_rf_wen); end
    clear_mem_inputs();
    mpc = RST_PC;
    s = '{32'h0000_0013, 1, 0, 0, 2'd0, 0, 32'h0, 0, 0};
    predict(s);
    drive_instr(s);
    e = sb.pop_front();
    checks++; if (o_retire !== 1'b1 || o_cycles != e.cycles || o_pc !== e.pc) begin errors++; $display("FAIL rmw_recover got r%b cyc %0d pc %h want r1 cyc %0d pc %h", o_retire, o_cycles, o_pc, e.cycles, e.pc); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_illegal();
    test_branch();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
